// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the multi-cycle shift unit (shift_seq) and its
//   single shared stage (shift_stage).
//   - Operation encodings SHIFT_SLL / SHIFT_SRL / SHIFT_SRA; 2'b11 is reserved
//     and treated as a pass-through by the datapath.
//   - Control state type for the top-level sequencer.
// ---------------------------------------------------------------------------
package shift_pkg;

   localparam logic [1:0] SHIFT_SLL = 2'b00;
   localparam logic [1:0] SHIFT_SRL = 2'b01;
   localparam logic [1:0] SHIFT_SRA = 2'b10;
   localparam logic [1:0] SHIFT_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//   Combinational single shift stage. The shift distance is 2^amt_sel, so the
//   sequencer can walk amt_sel through the shamt bit positions and reuse this
//   one block on every cycle.
// Ports
//   in       in   WIDTH    value to shift
//   amt_sel  in   SHAMT_W  stage index k; shift distance is 2^k
//   op       in   2        SHIFT_SLL / SHIFT_SRL / SHIFT_SRA; 2'b11 passes through
//   out      out  WIDTH    shifted value
// ---------------------------------------------------------------------------
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] amt_sel,
   input  logic [1:0]         op,
   output logic [WIDTH-1:0]   out
);

   logic signed [WIDTH-1:0] in_s;

   assign in_s = in;

   // Each candidate is a constant-distance shift; amt_sel picks one of them.
   // Indices with no matching stage fall through as a pass-through.
   always_comb begin
      out = in;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (amt_sel == SHAMT_W'(k)) begin
            case (op)
               SHIFT_SLL: out = in << (2 ** k);
               SHIFT_SRL: out = in >> (2 ** k);
               SHIFT_SRA: out = in_s >>> (2 ** k);
               default:   out = in;
            endcase
         end
      end
   end

endmodule

// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq
//   Multi-cycle shift unit. One shared shift_stage is applied once per shamt
//   bit (weights 2^(SHAMT_W-1) .. 1) to build SLL / SRL / SRA over several
//   cycles. Start pulse in, one-cycle result_rdy pulse out.
//
// Configuration macro
//   SHIFT_SKIP_EN  defined   : RUN visits only the set bits of shamt, highest
//                              first; shamt==0 goes straight to DONE.
//                  undefined : RUN always takes SHAMT_W cycles.
//   The produced result is the same in both builds.
//
// Ports
//   clock       in   1        rising-edge clock
//   reset_n     in   1        asynchronous active-low reset
//   ctrl_shift  in   1        start pulse, sampled only while busy==0
//   ctrl_flush  in   1        synchronous abort; beats a simultaneous start
//   op          in   2        shift operation, sampled with start
//   operand     in   WIDTH    value to shift, sampled with start
//   shamt       in   SHAMT_W  shift amount, sampled with start
//   result      out  WIDTH    shifted value, held until the next completion
//   result_rdy  out  1        one-cycle pulse, result valid
//   busy        out  1        high in RUN and DONE
// ---------------------------------------------------------------------------
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               ctrl_shift,
   input  logic               ctrl_flush,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   operand,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result,
   output logic               result_rdy,
   output logic               busy
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] rem;
   logic [1:0]         opr;

   logic [SHAMT_W-1:0] sel;
   logic [WIDTH-1:0]   stage_out;
   logic [WIDTH-1:0]   acc_step;
   logic               last;
   logic               accept;

`ifdef SHIFT_SKIP_EN
   logic [SHAMT_W-1:0] rem_clr;

   // Index of the highest set bit; 0 when nothing is set.
   function automatic logic [SHAMT_W-1:0] msb_idx(input logic [SHAMT_W-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (v[i]) msb_idx = SHAMT_W'(i);
      end
   endfunction

   assign sel      = msb_idx(rem);
   assign rem_clr  = rem & ~(SHAMT_W'(1) << sel);
   // Only set bits are visited, so the stage result is always taken.
   assign acc_step = stage_out;
   assign last     = (rem_clr == '0);
`else
   logic [SHAMT_W-1:0] step;

   assign sel      = step;
   // A clear shamt bit still costs a cycle but leaves acc untouched.
   assign acc_step = rem[step] ? stage_out : acc;
   assign last     = (step == '0);
`endif

   shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_stage (
      .in      (acc),
      .amt_sel (sel),
      .op      (opr),
      .out     (stage_out)
   );

   // Flush wins over a coincident start.
   assign accept = (state == IDLE) && ctrl_shift && !ctrl_flush;
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef SHIFT_SKIP_EN
               state_nxt = (shamt == '0) ? DONE : RUN;
`else
               state_nxt = RUN;
`endif
            end
         end
         RUN: begin
            if (ctrl_flush)  state_nxt = IDLE;
            else if (last)   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         acc        <= '0;
         rem        <= '0;
         opr        <= SHIFT_SLL;
         result     <= '0;
         result_rdy <= 1'b0;
`ifndef SHIFT_SKIP_EN
         step       <= '0;
`endif
      end else begin
         state      <= state_nxt;
         result_rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= operand;
                  rem <= shamt;
                  opr <= op;
`ifdef SHIFT_SKIP_EN
                  // Zero shift: the operand is already the answer.
                  if (shamt == '0) begin
                     result     <= operand;
                     result_rdy <= 1'b1;
                  end
`else
                  step <= SHAMT_W'(SHAMT_W - 1);
`endif
               end
            end
            RUN: begin
               if (!ctrl_flush) begin
                  acc <= acc_step;
`ifdef SHIFT_SKIP_EN
                  rem <= rem_clr;
`else
                  step <= step - 1'b1;
`endif
                  // Publish the final stage output on the edge entering DONE.
                  if (last) begin
                     result     <= acc_step;
                     result_rdy <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
